// File: rtl/fmc150_chirp_responder.sv
// fmc150_chirp_responder: the responder end of the chirp handshake in the
// FMC150 clock domain.
//
// Behaviour:
//   - Waits for dac_ready to stay high for HOLDOFF_CYCLES clocks, then
//     advertises chirp_ready.
//   - A chirp_init pulse starts a linear-FM chirp.
//   - While the chirp runs, one DDS phase-increment word is emitted per clock.
//   - A completed chirp produces a single chirp_done pulse.
//
// Optional feature (macro CHIRP_ABORT_EN):
//   When defined, chirp_enable low during ACTIVE aborts the chirp back to
//   READY. There is no done pulse and the chirp count does not change.
//   When undefined, chirp_enable is ignored.
module fmc150_chirp_responder #(
  parameter int unsigned HOLDOFF_CYCLES  = 4,
  parameter int unsigned CHIRP_CNT_WIDTH = 16
) (
  input  logic                       clk_fmc150,
  input  logic                       rst_fmc150,
  input  logic                       dac_ready,
  input  logic [127:0]               chirp_parameters_in,
  input  logic                       chirp_init,
  input  logic                       chirp_enable,
  output logic                       chirp_ready,
  output logic                       chirp_active,
  output logic                       chirp_done,
  output logic [31:0]                dds_phase_inc,
  output logic                       dds_valid,
  output logic [31:0]                chirp_sample_idx,
  output logic [CHIRP_CNT_WIDTH-1:0] chirp_count
);

  typedef enum logic [2:0] {
    IDLE,
    HOLDOFF,
    READY,
    ACTIVE,
    DONE
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF_CYCLES - 1);

  state_t                     state_q;
  logic [7:0]                 hold_q;
  logic [31:0]                coef_q;
  logic [31:0]                max_q;
  logic [31:0]                phase_q;
  logic [31:0]                idx_q;
  logic                       ready_q;
  logic                       active_q;
  logic                       done_q;
  logic [CHIRP_CNT_WIDTH-1:0] count_q;
  logic                       abort;

`ifdef CHIRP_ABORT_EN
  assign abort = ~chirp_enable;
  logic unused_params;
  assign unused_params = ^chirp_parameters_in[127:96];
`else
  assign abort = 1'b0;
  logic unused_params;
  assign unused_params = ^{chirp_parameters_in[127:96], chirp_enable};
`endif

  // Handshake FSM.
  // phase_q is both the DDS output register and the frequency accumulator;
  // it is zeroed whenever the FSM leaves ACTIVE.
  always_ff @(posedge clk_fmc150) begin
    if (rst_fmc150) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      coef_q   <= '0;
      max_q    <= '0;
      phase_q  <= '0;
      idx_q    <= '0;
      ready_q  <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (!dac_ready) begin
        state_q  <= IDLE;
        hold_q   <= '0;
        phase_q  <= '0;
        idx_q    <= '0;
        ready_q  <= 1'b0;
        active_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= HOLDOFF;
            hold_q  <= HOLD_LOAD;
          end
          HOLDOFF: begin
            if (hold_q == 8'd0) begin
              state_q <= READY;
              ready_q <= 1'b1;
            end else begin
              hold_q <= hold_q - 8'd1;
            end
          end
          READY: begin
            if (chirp_init) begin
              state_q  <= ACTIVE;
              ready_q  <= 1'b0;
              active_q <= 1'b1;
              coef_q   <= chirp_parameters_in[63:32];
              max_q    <= chirp_parameters_in[31:0];
              phase_q  <= chirp_parameters_in[95:64];
              idx_q    <= '0;
            end
          end
          ACTIVE: begin
            if (abort) begin
              state_q  <= READY;
              ready_q  <= 1'b1;
              active_q <= 1'b0;
              phase_q  <= '0;
              idx_q    <= '0;
            end else if (idx_q == max_q) begin
              state_q  <= DONE;
              active_q <= 1'b0;
              done_q   <= 1'b1;
              phase_q  <= '0;
              idx_q    <= '0;
              count_q  <= count_q + CHIRP_CNT_WIDTH'(1);
            end else begin
              phase_q <= phase_q + coef_q;
              idx_q   <= idx_q + 32'd1;
            end
          end
          DONE: begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign chirp_ready      = ready_q;
  assign chirp_active     = active_q;
  assign dds_valid        = active_q;
  assign chirp_done       = done_q;
  assign dds_phase_inc    = phase_q;
  assign chirp_sample_idx = idx_q;
  assign chirp_count      = count_q;

endmodule

// File: tb/tb_fmc150_chirp_responder.sv
// Scoreboard bench for fmc150_chirp_responder.
//
// Stimulus process: pushes expected samples and expected done counts.
// Monitor process: pops them when the DUT presents dds_valid or chirp_done.
module tb_fmc150_chirp_responder;

  logic         clk_fmc150;
  logic         rst_fmc150;
  logic         dac_ready;
  logic [127:0] chirp_parameters_in;
  logic         chirp_init;
  logic         chirp_enable;
  logic         chirp_ready;
  logic         chirp_active;
  logic         chirp_done;
  logic [31:0]  dds_phase_inc;
  logic         dds_valid;
  logic [31:0]  chirp_sample_idx;
  logic [15:0]  chirp_count;

  typedef struct {
    logic [31:0] phase;
    logic [31:0] idx;
  } samp_t;

  samp_t       exp_q[$];
  logic [15:0] cnt_exp_q[$];
  logic [15:0] cnt_model;
  int          total;
  int          bad;

  fmc150_chirp_responder #(
    .HOLDOFF_CYCLES (4),
    .CHIRP_CNT_WIDTH(16)
  ) dut (
    .clk_fmc150         (clk_fmc150),
    .rst_fmc150         (rst_fmc150),
    .dac_ready          (dac_ready),
    .chirp_parameters_in(chirp_parameters_in),
    .chirp_init         (chirp_init),
    .chirp_enable       (chirp_enable),
    .chirp_ready        (chirp_ready),
    .chirp_active       (chirp_active),
    .chirp_done         (chirp_done),
    .dds_phase_inc      (dds_phase_inc),
    .dds_valid          (dds_valid),
    .chirp_sample_idx   (chirp_sample_idx),
    .chirp_count        (chirp_count)
  );

  initial clk_fmc150 = 1'b0;
  always #5 clk_fmc150 = ~clk_fmc150;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_fmc150);
    #1;
  endtask

  task automatic push_samples(input logic [31:0] off, input logic [31:0] coef,
                              input logic [31:0] last);
    for (int unsigned k = 0; k <= last; k++) begin
      samp_t s;
      s.phase = off + coef * 32'(k);
      s.idx   = 32'(k);
      exp_q.push_back(s);
    end
  endtask

  // Count edges until chirp_ready goes high; 99 means it never did.
  task automatic wait_ready(output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (chirp_ready === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Full chirp. If stray is set, chirp_init is held high through ACTIVE and DONE.
  task automatic do_chirp(input logic [31:0] off, input logic [31:0] coef,
                          input logic [31:0] mx, input logic stray);
    int lat;
    chirp_parameters_in = {32'hDEAD_BEEF, off, coef, mx};
    push_samples(off, coef, mx);
    cnt_model++;
    cnt_exp_q.push_back(cnt_model);
    chirp_init = 1'b1;
    tick();
    chirp_init = stray;
    chirp_parameters_in = ~chirp_parameters_in;
    check("ready_low_in_active", {63'd0, chirp_ready}, 64'd0);
    lat = 0;
    while (chirp_done !== 1'b1 && lat < int'(mx) + 10) begin
      tick();
      lat++;
    end
    check("done_latency", 64'(lat), 64'(mx) + 64'd1);
    check("active_low_at_done", {63'd0, chirp_active}, 64'd0);
    tick();
    chirp_init = 1'b0;
    check("ready_after_done", {63'd0, chirp_ready}, 64'd1);
  endtask

  // Monitor: compare whatever the DUT presents against the scoreboard.
  always @(negedge clk_fmc150) begin
    if (rst_fmc150 === 1'b0) begin
      if (dds_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample", {32'd0, chirp_sample_idx}, 64'hFFFF_FFFF);
        end else begin
          samp_t s;
          s = exp_q.pop_front();
          check("sample_phase", {32'd0, dds_phase_inc}, {32'd0, s.phase});
          check("sample_idx", {32'd0, chirp_sample_idx}, {32'd0, s.idx});
          check("active_with_valid", {63'd0, chirp_active}, 64'd1);
        end
      end
      if (chirp_done === 1'b1) begin
        if (cnt_exp_q.size() == 0) begin
          check("unexpected_done", {48'd0, chirp_count}, 64'hFFFF);
        end else begin
          check("done_count", {48'd0, chirp_count}, {48'd0, cnt_exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    total               = 0;
    bad                 = 0;
    cnt_model           = '0;
    rst_fmc150          = 1'b1;
    dac_ready           = 1'b0;
    chirp_parameters_in = '0;
    chirp_init          = 1'b0;
    chirp_enable        = 1'b1;
    repeat (3) tick();
    check("rst_outputs", {chirp_ready, chirp_active, chirp_done, dds_valid,
                          dds_phase_inc, chirp_sample_idx[11:0], chirp_count},
          64'd0);
    rst_fmc150 = 1'b0;
    tick();

    // Holdoff: ready five edges after dac_ready rises.
    dac_ready = 1'b1;
    wait_ready(n);
    check("first_ready_latency", 64'(n), 64'd5);

    // Long chirp 0x600..0x15FF.
    do_chirp(32'h0000_0600, 32'd1, 32'h0000_0FFF, 1'b0);
    check("count_after_first", {48'd0, chirp_count}, 64'd1);

    // Phase wrap.
    do_chirp(32'h8000_0000, 32'h8000_0000, 32'd2, 1'b0);

    // Back-to-back single-sample chirps at minimum spacing, with stray inits.
    do_chirp(32'h1234_5678, 32'd7, 32'd0, 1'b1);
    do_chirp(32'hCAFE_0000, 32'd9, 32'd0, 1'b0);
    do_chirp(32'h0000_0010, 32'h10, 32'd3, 1'b1);
    check("count_after_b2b", {48'd0, chirp_count}, 64'd5);

    // chirp_enable dropped at sample 10 of 100.
    chirp_parameters_in = {32'd0, 32'h0000_1000, 32'd3, 32'd99};
`ifdef CHIRP_ABORT_EN
    push_samples(32'h0000_1000, 32'd3, 32'd10);
`else
    push_samples(32'h0000_1000, 32'd3, 32'd99);
    cnt_model++;
    cnt_exp_q.push_back(cnt_model);
`endif
    chirp_init = 1'b1;
    tick();
    chirp_init = 1'b0;
    repeat (10) tick();
    check("abort_pre_idx", {32'd0, chirp_sample_idx}, 64'd10);
    chirp_enable = 1'b0;
    tick();
    chirp_enable = 1'b1;
`ifdef CHIRP_ABORT_EN
    check("abort_valid_low", {63'd0, dds_valid}, 64'd0);
    check("abort_ready_high", {63'd0, chirp_ready}, 64'd1);
    check("abort_no_done", {63'd0, chirp_done}, 64'd0);
    check("abort_count", {48'd0, chirp_count}, {48'd0, cnt_model});
`else
    check("noabort_still_valid", {63'd0, dds_valid}, 64'd1);
    n = 11;
    while (chirp_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("noabort_done_latency", 64'(n), 64'd100);
    tick();
    check("noabort_ready", {63'd0, chirp_ready}, 64'd1);
`endif

    // dac_ready dropped mid-chirp, then holdoff again.
    chirp_parameters_in = {32'd0, 32'h0000_0100, 32'h0000_0002, 32'd50};
    push_samples(32'h0000_0100, 32'd2, 32'd5);
    chirp_init = 1'b1;
    tick();
    chirp_init = 1'b0;
    repeat (5) tick();
    dac_ready = 1'b0;
    tick();
    check("drop_outputs", {chirp_ready, chirp_active, chirp_done, dds_valid,
                           dds_phase_inc, chirp_sample_idx[27:0]}, 64'd0);
    check("drop_count", {48'd0, chirp_count}, {48'd0, cnt_model});
    repeat (2) tick();
    dac_ready = 1'b1;
    wait_ready(n);
    check("reready_latency", 64'(n), 64'd5);
    do_chirp(32'hFFFF_FFFE, 32'd1, 32'd3, 1'b0);

    repeat (3) tick();
    check("sample_queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_queue_empty", 64'(cnt_exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
